div_man_iter: RTL and testbench
===============================

DIV_MAN_ITER -- requirements
Module: div_man_iter

Interface
REQ-001 The block SHALL have parameter SIZE_DATA, default 24, giving the mantissa width including the hidden bit.
REQ-002 i_clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 i_rst_n  input  1  reset; it SHALL be synchronous and active-low.
REQ-004 i_valid  input  1  an operand pair is presented this cycle.
REQ-005 o_ready  output  1  the block is idle and can accept an operand pair.
REQ-006 i_data_a  input  SIZE_DATA  dividend mantissa, normalized (bit 23 = 1).
REQ-007 i_data_b  input  SIZE_DATA  divisor mantissa, normalized (bit 23 = 1), or zero.
REQ-008 o_valid  output  1  a result is presented and is held until accepted.
REQ-009 i_ready  input  1  the downstream stage accepts the result this cycle.
REQ-010 o_data_div  output  SIZE_DATA  normalized quotient mantissa, truncated.
REQ-011 o_norm_flag  output  1  quotient < 1; the exponent path SHALL decrement by 1.
REQ-012 o_rounding  output  1  round-to-nearest increment request: guard & (round | sticky).
REQ-013 o_div_zero  output  1  the divisor was zero (bit 23 = 0).

Function
REQ-014 An operand pair SHALL be captured on the cycle when i_valid and o_ready are both 1; operands SHALL NOT be sampled at any other time.
REQ-015 The FSM SHALL have three states: IDLE, CALC and DONE.
  - IDLE -> CALC on accept.
  - IDLE -> DONE on accept when i_data_b[23] = 0.
  - CALC -> DONE after the 27th iteration.
  - DONE -> IDLE when i_ready = 1.
REQ-016 o_ready SHALL equal 1 only in IDLE.
REQ-017 o_valid SHALL equal 1 only in DONE.
REQ-018 CALC SHALL run a restoring division that produces one quotient bit per cycle, MSB first, for exactly 27 cycles.
  - Result: Q = floor((A << 26) / B), 27 bits, always in [2^25, 2^27).
  - The remainder width SHALL be SIZE_DATA+1 bits.
REQ-019 When Q[26] = 1, the outputs SHALL be:
  - o_data_div = Q[26:3], guard = Q[2], round = Q[1].
  - sticky = Q[0] | (remainder != 0).
  - o_norm_flag = 0.
REQ-020 When Q[26] = 0, the outputs SHALL be:
  - o_data_div = Q[25:2], guard = Q[1], round = Q[0].
  - sticky = (remainder != 0).
  - o_norm_flag = 1.
REQ-021 Latency SHALL be 28 cycles from the accept edge to o_valid = 1 for a nonzero divisor, and 1 cycle for a zero divisor.
REQ-022 For a zero divisor the outputs SHALL be: o_div_zero = 1, o_data_div = all ones, o_norm_flag = 0, o_rounding = 0.
REQ-023 In DONE with i_ready = 0, all result outputs SHALL hold stable and o_ready SHALL stay 0.
REQ-024 i_valid asserted during CALC or DONE SHALL be ignored; no operand is captured and none is queued.
REQ-025 When DONE is accepted, the block SHALL return to IDLE; a new operand pair can be accepted at the earliest on the following cycle.
REQ-026 The quotient and the flags SHALL be registered outputs; there SHALL be no combinational path from any input to any output.

Reset
REQ-027 While i_rst_n = 0 at a clock edge, the FSM SHALL enter IDLE and the outputs SHALL be:
  - o_valid = 0, o_ready = 1.
  - o_data_div = 0, o_norm_flag = 0, o_rounding = 0, o_div_zero = 0.
  - The iteration counter, partial remainder and quotient registers SHALL be 0.
REQ-028 A reset asserted during CALC or DONE SHALL abort the operation; no o_valid SHALL appear for the aborted operands.

Structure
REQ-029 A shared package SHALL hold the SIZE_DATA default, the constant QUO_WIDTH = 27, the iteration-counter width (5 bits), and the FSM state enum.
REQ-030 Normalization, GRS extraction and the rounding flag SHALL be one combinational sub-module, div_man_norm; it takes Q and the remainder-nonzero bit and produces o_data_div, o_norm_flag and o_rounding.
REQ-031 The sub-module's outputs SHALL be registered in the top level on the CALC -> DONE transition.

Verification
REQ-032 a = 0x800000, b = 0x800000 -> after 28 cycles: o_data_div = 0x800000, o_norm_flag = 0, o_rounding = 0, o_div_zero = 0.
REQ-033 a = 0x800000, b = 0xC00000 -> Q = 0x2AAAAAA; o_data_div = 0xAAAAAA, o_norm_flag = 1, o_rounding = 1.
REQ-034 a = 0xFFFFFF, b = 0x800000 -> o_data_div = 0xFFFFFF, o_norm_flag = 0, o_rounding = 0.
REQ-035 a = 0x900000, b = 0x000000 -> o_valid one cycle after accept; o_div_zero = 1, o_data_div = 0xFFFFFF.
REQ-036 Backpressure: hold i_ready = 0 for 10 cycles in DONE -> outputs stable, o_ready = 0, and an i_valid pulse in that window is ignored; then i_ready = 1 -> o_ready = 1 on the next cycle.
REQ-037 Assert i_rst_n = 0 at iteration 12 of CALC -> o_valid never rises for those operands; after reset release, a new pair a = b = 0xC00000 yields 0x800000.

Source files
------------

// File: rtl/div_man_iter_pkg.sv
// Shared constants and FSM state type for the iterative mantissa divider.
package div_man_iter_pkg;

    // Default mantissa width, hidden bit included.
    localparam int SIZE_DATA_DEF = 24;

    // Quotient bits produced by the restoring loop: one integer bit, the
    // 23 fraction bits of a normalized result, plus guard and round bits
    // (with one spare bit when the quotient is below 1).
    localparam int QUO_WIDTH = 27;

    // Iteration counter width; must hold the value QUO_WIDTH.
    localparam int CNT_WIDTH = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/div_man_norm.sv
// Normalizes the raw restoring-division quotient, extracts guard/round/sticky
// bits and forms the round-to-nearest increment request. Purely combinational.
module div_man_norm
    import div_man_iter_pkg::*;
#(
    parameter int SIZE_DATA = SIZE_DATA_DEF
) (
    input  logic [SIZE_DATA+2:0] i_quo,
    input  logic                 i_rem_nz,
    output logic [SIZE_DATA-1:0] o_data_div,
    output logic                 o_norm_flag,
    output logic                 o_rounding
);

    logic guard;
    logic round_bit;
    logic sticky;

    // Pick the mantissa window from the quotient MSB and collect the GRS bits.
    always_comb begin
        o_data_div  = '0;
        o_norm_flag = 1'b0;
        guard       = 1'b0;
        round_bit   = 1'b0;
        sticky      = 1'b0;
        if (i_quo[SIZE_DATA+2]) begin
            // Quotient in [1,2): already normalized.
            o_data_div  = i_quo[SIZE_DATA+2:3];
            guard       = i_quo[2];
            round_bit   = i_quo[1];
            sticky      = i_quo[0] | i_rem_nz;
            o_norm_flag = 1'b0;
        end else begin
            // Quotient in [0.5,1): shift left by one, exponent drops by 1.
            o_data_div  = i_quo[SIZE_DATA+1:2];
            guard       = i_quo[1];
            round_bit   = i_quo[0];
            sticky      = i_rem_nz;
            o_norm_flag = 1'b1;
        end
        o_rounding = guard & (round_bit | sticky);
    end

endmodule

// File: rtl/div_man_iter.sv
// Iterative restoring mantissa divider: one quotient bit per clock, MSB first.
//
// Handshake: an operand pair is taken on a rising edge where i_valid and
// o_ready are both 1; a result is handed over on a rising edge where o_valid
// and i_ready are both 1. o_ready is 1 only when idle and o_valid only while a
// result is held, so the block never holds more than one operation.
module div_man_iter
    import div_man_iter_pkg::*;
#(
    parameter int SIZE_DATA = SIZE_DATA_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [SIZE_DATA-1:0] i_data_a,
    input  logic [SIZE_DATA-1:0] i_data_b,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [SIZE_DATA-1:0] o_data_div,
    output logic                 o_norm_flag,
    output logic                 o_rounding,
    output logic                 o_div_zero,
    output state_e               o_dbg_state
);

    localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(QUO_WIDTH - 1);

    state_e                 state_q;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic [SIZE_DATA:0]     rem_q;
    logic [QUO_WIDTH-1:0]   quo_q;
    logic [SIZE_DATA-1:0]   divisor_q;
    logic [SIZE_DATA-1:0]   data_q;
    logic                   norm_q;
    logic                   rnd_q;
    logic                   divz_q;
    logic                   valid_q;
    logic                   ready_q;

    logic                   ge_d;
    logic [SIZE_DATA:0]     rem_sel_d;
    logic [SIZE_DATA:0]     rem_shl_d;
    logic [QUO_WIDTH-1:0]   quo_d;
    logic                   last_iter_d;

    logic [SIZE_DATA-1:0]   norm_data;
    logic                   norm_flag;
    logic                   norm_rnd;

    // One restoring step: trial-subtract the divisor, keep the difference if
    // it did not go negative, and shift the new quotient bit in at the LSB.
    // The partial remainder stays below twice the divisor, so SIZE_DATA+1
    // bits are enough.
    always_comb begin
        ge_d        = (rem_q >= {1'b0, divisor_q});
        rem_sel_d   = ge_d ? (rem_q - {1'b0, divisor_q}) : rem_q;
        rem_shl_d   = {rem_sel_d[SIZE_DATA-1:0], 1'b0};
        quo_d       = {quo_q[QUO_WIDTH-2:0], ge_d};
        last_iter_d = (cnt_q == LAST_ITER);
    end

    // Fed with the quotient and remainder of the final step so the results
    // can be latched on the same edge that enters DONE.
    div_man_norm #(
        .SIZE_DATA (SIZE_DATA)
    ) u_norm (
        .i_quo       (quo_d),
        .i_rem_nz    (|rem_sel_d),
        .o_data_div  (norm_data),
        .o_norm_flag (norm_flag),
        .o_rounding  (norm_rnd)
    );

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            data_q    <= '0;
            norm_q    <= 1'b0;
            rnd_q     <= 1'b0;
            divz_q    <= 1'b0;
            valid_q   <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        divisor_q <= i_data_b;
                        rem_q     <= {1'b0, i_data_a};
                        quo_q     <= '0;
                        cnt_q     <= '0;
                        ready_q   <= 1'b0;
                        if (!i_data_b[SIZE_DATA-1]) begin
                            // Divisor is zero: skip the loop entirely.
                            state_q <= DONE;
                            valid_q <= 1'b1;
                            data_q  <= '1;
                            norm_q  <= 1'b0;
                            rnd_q   <= 1'b0;
                            divz_q  <= 1'b1;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end

                CALC: begin
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + CNT_WIDTH'(1);
                    if (last_iter_d) begin
                        // Keep the final remainder unshifted.
                        rem_q   <= rem_sel_d;
                        state_q <= DONE;
                        valid_q <= 1'b1;
                        data_q  <= norm_data;
                        norm_q  <= norm_flag;
                        rnd_q   <= norm_rnd;
                        divz_q  <= 1'b0;
                    end else begin
                        rem_q <= rem_shl_d;
                    end
                end

                DONE: begin
                    if (i_ready) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign o_ready     = ready_q;
    assign o_valid     = valid_q;
    assign o_data_div  = data_q;
    assign o_norm_flag = norm_q;
    assign o_rounding  = rnd_q;
    assign o_div_zero  = divz_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_div_man_iter.sv
// Directed bench for div_man_iter: table of operand pairs with hand-computed
// quotients, then backpressure and reset-abort sequences.
module tb_div_man_iter;
    import div_man_iter_pkg::*;

    logic         i_clk;
    logic         i_rst_n;
    logic         i_valid;
    logic         o_ready;
    logic [23:0]  i_data_a;
    logic [23:0]  i_data_b;
    logic         o_valid;
    logic         i_ready;
    logic [23:0]  o_data_div;
    logic         o_norm_flag;
    logic         o_rounding;
    logic         o_div_zero;
    state_e       o_dbg_state;

    int n_tests;
    int n_fail;

    typedef struct {
        logic [23:0] a;
        logic [23:0] b;
        logic [23:0] exp_data;
        logic        exp_norm;
        logic        exp_rnd;
        logic        exp_divz;
        int          exp_lat;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs[NVEC];

    div_man_iter #(.SIZE_DATA(24)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_data_a    (i_data_a),
        .i_data_b    (i_data_b),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_data_div  (o_data_div),
        .o_norm_flag (o_norm_flag),
        .o_rounding  (o_rounding),
        .o_div_zero  (o_div_zero),
        .o_dbg_state (o_dbg_state)
    );

    // Clock
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Present one operand pair, then wait (bounded) for o_valid.
    // Returns with time just after the edge where o_valid was first seen.
    task automatic do_op(input logic [23:0] a, input logic [23:0] b, output int lat);
        @(negedge i_clk);
        check("ready_before_accept", {31'd0, o_ready}, 32'd1);
        i_data_a = a;
        i_data_b = b;
        i_valid  = 1'b1;
        @(posedge i_clk);
        #1;
        i_valid  = 1'b0;
        // Scramble the operand bus: the block must not resample it.
        i_data_a = 24'($urandom);
        i_data_b = 24'($urandom);
        lat = 1;
        while (!o_valid && lat < 60) begin
            @(posedge i_clk);
            #1;
            lat++;
        end
    endtask

    int lat;
    int seen;

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        i_rst_n  = 1'b0;
        i_valid  = 1'b0;
        i_ready  = 1'b1;
        i_data_a = 24'h0;
        i_data_b = 24'h0;

        //            a          b          data       norm  rnd   divz  lat
        vecs[0]  = '{24'h800000, 24'h800000, 24'h800000, 1'b0, 1'b0, 1'b0, 28};
        vecs[1]  = '{24'h800000, 24'hC00000, 24'hAAAAAA, 1'b1, 1'b1, 1'b0, 28};
        vecs[2]  = '{24'hFFFFFF, 24'h800000, 24'hFFFFFF, 1'b0, 1'b0, 1'b0, 28};
        vecs[3]  = '{24'h900000, 24'h000000, 24'hFFFFFF, 1'b0, 1'b0, 1'b1, 1};
        vecs[4]  = '{24'hC00000, 24'hC00000, 24'h800000, 1'b0, 1'b0, 1'b0, 28};
        vecs[5]  = '{24'hC00000, 24'h800000, 24'hC00000, 1'b0, 1'b0, 1'b0, 28};
        vecs[6]  = '{24'h800000, 24'hFFFFFF, 24'h800000, 1'b1, 1'b1, 1'b0, 28};
        vecs[7]  = '{24'hFFFFFF, 24'hFFFFFF, 24'h800000, 1'b0, 1'b0, 1'b0, 28};
        vecs[8]  = '{24'h800001, 24'h800000, 24'h800001, 1'b0, 1'b0, 1'b0, 28};
        vecs[9]  = '{24'hA00000, 24'hC00000, 24'hD55555, 1'b1, 1'b0, 1'b0, 28};
        vecs[10] = '{24'hC00000, 24'hA00000, 24'h999999, 1'b0, 1'b1, 1'b0, 28};

        // Reset
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_ready",  {31'd0, o_ready},     32'd1);
        check("rst_valid",  {31'd0, o_valid},     32'd0);
        check("rst_data",   {8'd0, o_data_div},   32'd0);
        check("rst_norm",   {31'd0, o_norm_flag}, 32'd0);
        check("rst_rnd",    {31'd0, o_rounding},  32'd0);
        check("rst_divz",   {31'd0, o_div_zero},  32'd0);
        check("rst_state",  {30'd0, o_dbg_state}, {30'd0, IDLE});
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        check("idle_no_valid", {31'd0, o_valid}, 32'd0);

        // Table-driven vectors
        for (int i = 0; i < NVEC; i++) begin
            do_op(vecs[i].a, vecs[i].b, lat);
            check($sformatf("v%0d_latency", i), 32'(lat),              32'(vecs[i].exp_lat));
            check($sformatf("v%0d_valid", i),   {31'd0, o_valid},      32'd1);
            check($sformatf("v%0d_ready", i),   {31'd0, o_ready},      32'd0);
            check($sformatf("v%0d_data", i),    {8'd0, o_data_div},    {8'd0, vecs[i].exp_data});
            check($sformatf("v%0d_norm", i),    {31'd0, o_norm_flag},  {31'd0, vecs[i].exp_norm});
            check($sformatf("v%0d_rnd", i),     {31'd0, o_rounding},   {31'd0, vecs[i].exp_rnd});
            check($sformatf("v%0d_divz", i),    {31'd0, o_div_zero},   {31'd0, vecs[i].exp_divz});
            @(posedge i_clk);
            #1;
            check($sformatf("v%0d_release_ready", i), {31'd0, o_ready}, 32'd1);
            check($sformatf("v%0d_release_valid", i), {31'd0, o_valid}, 32'd0);
        end

        // Backpressure: hold the result for 10 cycles, poke i_valid meanwhile
        i_ready = 1'b0;
        do_op(24'hC00000, 24'hA00000, lat);
        check("bp_latency", 32'(lat), 32'd28);
        for (int c = 0; c < 10; c++) begin
            if (c == 4) begin
                @(negedge i_clk);
                i_data_a = 24'h800000;
                i_data_b = 24'h800000;
                i_valid  = 1'b1;
            end
            @(posedge i_clk);
            #1;
            i_valid = 1'b0;
            check($sformatf("bp%0d_valid", c), {31'd0, o_valid},     32'd1);
            check($sformatf("bp%0d_ready", c), {31'd0, o_ready},     32'd0);
            check($sformatf("bp%0d_data", c),  {8'd0, o_data_div},   32'h00999999);
            check($sformatf("bp%0d_norm", c),  {31'd0, o_norm_flag}, 32'd0);
            check($sformatf("bp%0d_rnd", c),   {31'd0, o_rounding},  32'd1);
            check($sformatf("bp%0d_divz", c),  {31'd0, o_div_zero},  32'd0);
        end
        @(negedge i_clk);
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        check("bp_release_ready", {31'd0, o_ready}, 32'd1);
        check("bp_release_valid", {31'd0, o_valid}, 32'd0);
        // The ignored pulse must not have been queued.
        seen = 0;
        for (int c = 0; c < 35; c++) begin
            @(posedge i_clk);
            #1;
            if (o_valid) seen++;
        end
        check("bp_no_queued_op", 32'(seen), 32'd0);

        // Reset during CALC at iteration 12
        @(negedge i_clk);
        i_data_a = 24'h800000;
        i_data_b = 24'hC00000;
        i_valid  = 1'b1;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        repeat (11) @(posedge i_clk);
        #1;
        check("abort_in_calc", {30'd0, o_dbg_state}, {30'd0, CALC});
        @(negedge i_clk);
        i_rst_n = 1'b0;
        @(posedge i_clk);
        #1;
        check("abort_state", {30'd0, o_dbg_state}, {30'd0, IDLE});
        check("abort_ready", {31'd0, o_ready},     32'd1);
        check("abort_valid", {31'd0, o_valid},     32'd0);
        check("abort_data",  {8'd0, o_data_div},   32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge i_clk);
            #1;
            if (o_valid) seen++;
        end
        check("abort_no_valid", 32'(seen), 32'd0);
        do_op(24'hC00000, 24'hC00000, lat);
        check("post_abort_latency", 32'(lat),             32'd28);
        check("post_abort_data",    {8'd0, o_data_div},   32'h00800000);
        check("post_abort_norm",    {31'd0, o_norm_flag}, 32'd0);
        check("post_abort_rnd",     {31'd0, o_rounding},  32'd0);
        @(posedge i_clk);
        #1;
        check("post_abort_release", {31'd0, o_ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
